// File: rtl/divider_array_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : divider_array_share_ctrl (+ divider_array_core)
// Brief    : Round-robin sharing of one combinational 16/8 array divider
//            between two requesters, with up-front divide-by-zero/overflow.
// Revision : 1.0
// ============================================================================

// Restoring array divider: one compare/subtract row per quotient bit.
// Results are meaningful only when i_n[15:8] < i_d (the wrapper screens the rest).
module divider_array_core (
  input  logic [15:0] i_n,
  input  logic [7:0]  i_d,
  output logic [7:0]  o_q,
  output logic [7:0]  o_r
);
  logic [7:0] w_rem [0:8];

  assign w_rem[0] = i_n[15:8];

  for (genvar i = 0; i < 8; i++) begin : g_stage
    logic [8:0] w_t;
    logic       w_ge;
    assign w_t          = {w_rem[i], i_n[7-i]};
    assign w_ge         = (w_t >= {1'b0, i_d});
    assign o_q[7-i]     = w_ge;
    // Partial remainder stays below i_d, so the low byte of the difference is exact.
    assign w_rem[i+1]   = w_ge ? (w_t[7:0] - i_d) : w_t[7:0];
  end

  assign o_r = w_rem[8];
endmodule

module divider_array_share_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_0,
  input  logic        req_valid_1,
  output logic        req_ready_0,
  output logic        req_ready_1,
  input  logic [15:0] req_n_0,
  input  logic [15:0] req_n_1,
  input  logic [7:0]  req_d_0,
  input  logic [7:0]  req_d_1,
  output logic        rsp_valid_0,
  output logic        rsp_valid_1,
  input  logic        rsp_ready_0,
  input  logic        rsp_ready_1,
  output logic [7:0]  rsp_q,
  output logic [7:0]  rsp_r,
  output logic [1:0]  rsp_err,
  output logic        busy,
  output logic [15:0] ops_done,
  output logic [7:0]  err_count
);
  localparam logic [1:0] C_ERR_OK   = 2'b00;
  localparam logic [1:0] C_ERR_DZ   = 2'b01;
  localparam logic [1:0] C_ERR_OVF  = 2'b10;
  localparam logic [3:0] C_CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_n;
  logic [7:0]  r_d;
  logic [3:0]  r_cnt;
  logic        r_owner;
  logic        r_last_grant;
  logic [7:0]  r_q;
  logic [7:0]  r_r;
  logic [1:0]  r_err;
  logic [15:0] r_ops_done;
  logic [7:0]  r_err_count;

  logic        w_idle;
  logic        w_grant_0;
  logic        w_grant_1;
  logic        w_accept;
  logic        w_sel;
  logic [15:0] w_in_n;
  logic [7:0]  w_in_d;
  logic        w_dz;
  logic        w_ovf;
  logic        w_rsp_ready_own;
  logic [7:0]  w_core_q;
  logic [7:0]  w_core_r;

  divider_array_core u_core (
    .i_n (r_n),
    .i_d (r_d),
    .o_q (w_core_q),
    .o_r (w_core_r)
  );

  // On a tie the requester that did not win last time is granted.
  assign w_idle      = (r_state == S_IDLE);
  assign w_grant_0   = req_valid_0 & (~req_valid_1 | r_last_grant);
  assign w_grant_1   = req_valid_1 & (~req_valid_0 | ~r_last_grant);
  assign req_ready_0 = w_idle & w_grant_0;
  assign req_ready_1 = w_idle & w_grant_1;
  assign w_accept    = req_ready_0 | req_ready_1;
  assign w_sel       = req_ready_1;
  assign w_in_n      = w_sel ? req_n_1 : req_n_0;
  assign w_in_d      = w_sel ? req_d_1 : req_d_0;
  assign w_dz        = (w_in_d == 8'd0);
  assign w_ovf       = (w_in_n[15:8] >= w_in_d);

  assign w_rsp_ready_own = r_owner ? rsp_ready_1 : rsp_ready_0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = (w_dz | w_ovf) ? S_RESP : S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_cnt == 4'd0) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        if (w_rsp_ready_own) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n          <= 16'd0;
      r_d          <= 8'd0;
      r_cnt        <= 4'd0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_q          <= 8'd0;
      r_r          <= 8'd0;
      r_err        <= C_ERR_OK;
      r_ops_done   <= 16'd0;
      r_err_count  <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_n          <= w_in_n;
            r_d          <= w_in_d;
            r_owner      <= w_sel;
            r_last_grant <= w_sel;
            if (w_dz) begin
              r_err <= C_ERR_DZ;
              r_q   <= 8'hFF;
              r_r   <= w_in_n[7:0];
            end else if (w_ovf) begin
              r_err <= C_ERR_OVF;
              r_q   <= 8'hFF;
              r_r   <= 8'hFF;
            end else begin
              r_err <= C_ERR_OK;
              r_cnt <= C_CNT_LOAD;
            end
          end
        end
        S_SETTLE: begin
          if (r_cnt == 4'd0) begin
            r_q <= w_core_q;
            r_r <= w_core_r;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (w_rsp_ready_own) begin
            r_ops_done <= r_ops_done + 16'd1;
            if ((r_err != C_ERR_OK) && (r_err_count != 8'hFF)) begin
              r_err_count <= r_err_count + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid_0 = (r_state == S_RESP) & ~r_owner;
  assign rsp_valid_1 = (r_state == S_RESP) &  r_owner;
  assign rsp_q       = r_q;
  assign rsp_r       = r_r;
  assign rsp_err     = r_err;
  assign busy        = ~w_idle;
  assign ops_done    = r_ops_done;
  assign err_count   = r_err_count;
endmodule
`default_nettype wire

// File: tb/tb_divider_array_share_ctrl.sv
`default_nettype none
// Bench for divider_array_share_ctrl: transaction-level model of the two
// requesters and the shared divider, compared against the DUT every cycle.
module tb_divider_array_share_ctrl;
  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v  [2];
  logic [15:0] n  [2];
  logic [7:0]  d  [2];
  logic        rr [2];
  logic        req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, busy;
  logic [7:0]  rsp_q, rsp_r, err_count;
  logic [1:0]  rsp_err;
  logic [15:0] ops_done;

  always #5 clk = ~clk;

  divider_array_share_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(v[0]), .req_valid_1(v[1]),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_n_0(n[0]), .req_n_1(n[1]), .req_d_0(d[0]), .req_d_1(d[1]),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
    .rsp_ready_0(rr[0]), .rsp_ready_1(rr[1]),
    .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_err(rsp_err),
    .busy(busy), .ops_done(ops_done), .err_count(err_count)
  );

  int checks = 0, errors = 0, cyc = 0;
  // model state: one outstanding transaction
  bit         m_act = 0, m_own = 0, m_last = 1;
  int         m_rc = 0, m_ops = 0, m_errc = 0;
  logic [7:0] m_q, m_r;
  logic [1:0] m_err;
  bit         acc_flag, acc_who, done_flag, prev_rv;
  logic [7:0] last_q, last_r;
  logic [1:0] last_err;
  int         acc_cyc, rv_cyc;
  bit         glog[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
  endtask

  // Plain arithmetic reference of what a request must return.
  task automatic model_op(input logic [15:0] nn, input logic [7:0] dd);
    int qi, ri;
    if (dd == 8'd0) begin
      m_err = 2'b01; m_q = 8'hFF; m_r = nn[7:0];
    end else if (int'(nn) / 256 >= int'(dd)) begin
      m_err = 2'b10; m_q = 8'hFF; m_r = 8'hFF;
    end else begin
      qi = int'(nn) / int'(dd);
      ri = int'(nn) % int'(dd);
      m_err = 2'b00; m_q = qi[7:0]; m_r = ri[7:0];
    end
  endtask

  // One clock: compare at negedge, advance model, return at posedge+1.
  task automatic tick();
    bit g0, g1, ev0, ev1;
    @(negedge clk);
    g0  = !m_act && v[0] && (!v[1] || m_last);
    g1  = !m_act && v[1] && (!v[0] || !m_last);
    ev0 = m_act && (cyc >= m_rc) && !m_own;
    ev1 = m_act && (cyc >= m_rc) &&  m_own;
    chk("req_ready_0", req_ready_0, g0);
    chk("req_ready_1", req_ready_1, g1);
    chk("rsp_valid_0", rsp_valid_0, ev0);
    chk("rsp_valid_1", rsp_valid_1, ev1);
    chk("busy", busy, m_act);
    chk("ops_done", ops_done, m_ops[15:0]);
    chk("err_count", err_count, m_errc[7:0]);
    if (ev0 || ev1) begin
      chk("rsp_q", rsp_q, m_q);
      chk("rsp_r", rsp_r, m_r);
      chk("rsp_err", rsp_err, m_err);
    end
    if (req_ready_0 || req_ready_1) begin
      acc_cyc = cyc;
      glog.push_back(req_ready_1);
    end
    if ((rsp_valid_0 || rsp_valid_1) && !prev_rv) rv_cyc = cyc;
    prev_rv   = rsp_valid_0 || rsp_valid_1;
    acc_flag  = 0;
    done_flag = 0;
    if (g0 || g1) begin
      acc_flag = 1; acc_who = g1; m_own = g1; m_last = g1;
      model_op(n[g1], d[g1]);
      m_rc  = cyc + ((m_err != 2'b00) ? 1 : S + 1);
      m_act = 1;
    end else if ((ev0 || ev1) && rr[m_own]) begin
      done_flag = 1;
      last_q = rsp_q; last_r = rsp_r; last_err = rsp_err;
      m_ops = (m_ops + 1) & 16'hFFFF;
      if (m_err != 2'b00 && m_errc < 255) m_errc++;
      m_act = 0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input string name);
    int k = 0;
    do begin tick(); k++; end while (!acc_flag && k < 50);
    if (!acc_flag) timeout_fail(name);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (m_act && k < 200) begin tick(); k++; end
    if (m_act) timeout_fail(name);
  endtask

  task automatic run_op(input int who, input logic [15:0] nn, input logic [7:0] dd, input string name);
    v[who] = 1; n[who] = nn; d[who] = dd; rr[who] = 1;
    wait_acc(name);
    v[who] = 0;
    wait_idle(name);
  endtask

  task automatic gen(input int who);
    int kind, dd, hi;
    kind = $urandom_range(0, 9);
    if (kind == 0) begin
      dd = 0; hi = $urandom_range(0, 255);
    end else if (kind == 1) begin
      dd = $urandom_range(1, 255); hi = $urandom_range(dd, 255);
    end else begin
      dd = $urandom_range(1, 255); hi = $urandom_range(0, dd - 1);
    end
    n[who] = 16'(hi * 256 + $urandom_range(0, 255));
    d[who] = dd[7:0];
    v[who] = 1;
  endtask

  task automatic model_reset();
    m_act = 0; m_ops = 0; m_errc = 0; m_last = 1; prev_rv = 0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin v[i] = 0; n[i] = 0; d[i] = 0; rr[i] = 0; end
    repeat (3) @(posedge clk);
    #1;
    chk("reset req_ready_0", req_ready_0, 0);
    chk("reset rsp_valid_0", rsp_valid_0, 0);
    chk("reset rsp_valid_1", rsp_valid_1, 0);
    chk("reset rsp_q", rsp_q, 0);
    chk("reset rsp_err", rsp_err, 0);
    chk("reset busy", busy, 0);
    chk("reset ops_done", ops_done, 0);
    rst_n = 1;

    run_op(0, 16'h03E8, 8'h0A, "single");
    chk("single q", last_q, 8'h64);
    chk("single r", last_r, 8'h00);
    chk("single err", last_err, 2'b00);
    chk("single latency", rv_cyc - acc_cyc, 3);
    chk("single ops_done", ops_done, 1);

    run_op(1, 16'h1234, 8'h00, "div0");
    chk("div0 q", last_q, 8'hFF);
    chk("div0 r", last_r, 8'h34);
    chk("div0 err", last_err, 2'b01);
    chk("div0 latency", rv_cyc - acc_cyc, 1);
    chk("div0 err_count", err_count, 1);

    run_op(0, 16'h0A00, 8'h0A, "ovf");
    chk("ovf q", last_q, 8'hFF);
    chk("ovf r", last_r, 8'hFF);
    chk("ovf err", last_err, 2'b10);

    run_op(0, 16'h09FF, 8'h0A, "edge");
    chk("edge q", last_q, 8'hFF);
    chk("edge r", last_r, 8'h09);
    chk("edge err", last_err, 2'b00);
    chk("edge latency", rv_cyc - acc_cyc, 3);

    // back-pressure on requester 0 while requester 1 waits
    v[0] = 1; n[0] = 16'h1357; d[0] = 8'h42; rr[0] = 0;
    wait_acc("bp accept");
    v[0] = 0; v[1] = 1; n[1] = 16'h0100; d[1] = 8'h03;
    begin
      int k = 0;
      while (!(m_act && cyc >= m_rc) && k < 20) begin tick(); k++; end
      if (!(m_act && cyc >= m_rc)) timeout_fail("bp response");
    end
    repeat (10) tick();
    chk("bp busy", busy, 1);
    chk("bp rsp_valid_0", rsp_valid_0, 1);
    chk("bp req_ready_1", req_ready_1, 0);
    rr[0] = 1; rr[1] = 1;
    tick();
    chk("bp idle next", busy, 0);
    chk("bp next ready", req_ready_1, 1);
    wait_acc("bp second");
    v[1] = 0;
    wait_idle("bp drain");

    for (int k = 0; k < 3000; k++) begin
      for (int w = 0; w < 2; w++) begin
        if (!v[w] && $urandom_range(0, 2) == 0) gen(w);
        rr[w] = ($urandom_range(0, 2) != 0);
      end
      tick();
      if (acc_flag) v[acc_who] = 0;
    end
    v[0] = 0; v[1] = 0; rr[0] = 1; rr[1] = 1;
    wait_idle("random drain");

    // reset in the middle of SETTLE
    v[0] = 1; n[0] = 16'h03E8; d[0] = 8'h0A;
    wait_acc("rst accept");
    v[0] = 0;
    rst_n = 0;
    #1;
    chk("mid-rst busy", busy, 0);
    chk("mid-rst rsp_valid_0", rsp_valid_0, 0);
    chk("mid-rst rsp_q", rsp_q, 0);
    chk("mid-rst rsp_r", rsp_r, 0);
    chk("mid-rst rsp_err", rsp_err, 0);
    chk("mid-rst ops_done", ops_done, 0);
    chk("mid-rst err_count", err_count, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    repeat (8) tick();

    // contention: both requesters valid continuously
    glog.delete();
    gen(0); gen(1);
    begin
      int accs = 0, k = 0;
      while (accs < 6 && k < 200) begin
        tick(); k++;
        if (acc_flag) begin accs++; gen(acc_who); end
      end
      if (accs < 6) timeout_fail("contention");
    end
    v[0] = 0; v[1] = 0;
    wait_idle("contention drain");
    chk("grant count", (glog.size() >= 6) ? 1 : 0, 1);
    for (int i = 0; i < 6 && i < glog.size(); i++)
      chk($sformatf("grant[%0d]", i), glog[i], i % 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
